// File: rtl/digit_serial_addsub_if.sv
// Request/result handshake bundle for the digit-serial adder/subtractor.
// The requester drives operands and done_ready; the datapath drives results.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, a_in, b_in, sub, done_ready,
        input  start_ready, sum_out, cout, ovf, zero, done_valid
    );

    modport slave (
        input  start_valid, a_in, b_in, sub, done_ready,
        output start_ready, sum_out, cout, ovf, zero, done_valid
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock through a full-adder ripple,
// digit carry kept in a register, NDIG = WIDTH/DIGIT cycles per operation.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = (DIGIT < 1) ? 1 : WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
            $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r, sum_r;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              cout_r, ovf_r, zero_r;
    logic              start_ready, done_valid;

    logic [DIGIT:0]       c;
    logic [DIGIT-1:0]     s;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]     sum_shift;
    logic                 last, accept;

    assign c[0] = carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            full_adder u_fa (
                .a  (a_r[i]),
                .b  (b_r[i]),
                .ci (c[i]),
                .s  (s[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    // New digit enters at the MSB end; after NDIG shifts the result is aligned.
    assign cat       = {s, sum_r};
    assign sum_shift = cat[WIDTH+DIGIT-1:DIGIT];
    assign last      = (cnt == CW'(NDIG - 1));
    assign accept    = bus.start_valid && start_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (bus.done_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= bus.a_in;
                        b_r   <= bus.b_in ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    sum_r <= sum_shift;
                    carry <= c[DIGIT];
                    if (last) begin
                        cout_r <= c[DIGIT];
                        // c[DIGIT-1] is the carry into the MSB on the final digit
                        ovf_r  <= c[DIGIT] ^ c[DIGIT-1];
                        zero_r <= (sum_shift == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = start_ready;
    assign bus.done_valid  = done_valid;
    assign bus.sum_out     = sum_r;
    assign bus.cout        = cout_r;
    assign bus.ovf         = ovf_r;
    assign bus.zero        = zero_r;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: DIGIT=4, 1 and 16 instances checked against
// a plain-arithmetic {ovf,zero,cout,sum} model with directed and random ops.
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] ta, tbv;
    logic        ts;
    logic        sv [3];
    logic        dr [3];
    logic        sr [3], dv [3], co [3], ov [3], zr [3];
    logic [15:0] so [3];

    int vectors = 0;
    int miscompares = 0;

    digit_serial_addsub_if #(.WIDTH(16)) if0 ();
    digit_serial_addsub_if #(.WIDTH(16)) if1 ();
    digit_serial_addsub_if #(.WIDTH(16)) if2 ();

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4))  u0 (.clk(clk), .rst(rst), .bus(if0));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(1))  u1 (.clk(clk), .rst(rst), .bus(if1));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.a_in = ta;  assign if0.b_in = tbv; assign if0.sub = ts;
    assign if1.a_in = ta;  assign if1.b_in = tbv; assign if1.sub = ts;
    assign if2.a_in = ta;  assign if2.b_in = tbv; assign if2.sub = ts;
    assign if0.start_valid = sv[0]; assign if0.done_ready = dr[0];
    assign if1.start_valid = sv[1]; assign if1.done_ready = dr[1];
    assign if2.start_valid = sv[2]; assign if2.done_ready = dr[2];

    assign sr[0] = if0.start_ready; assign dv[0] = if0.done_valid; assign so[0] = if0.sum_out;
    assign co[0] = if0.cout; assign ov[0] = if0.ovf; assign zr[0] = if0.zero;
    assign sr[1] = if1.start_ready; assign dv[1] = if1.done_valid; assign so[1] = if1.sum_out;
    assign co[1] = if1.cout; assign ov[1] = if1.ovf; assign zr[1] = if1.zero;
    assign sr[2] = if2.start_ready; assign dv[2] = if2.done_valid; assign so[2] = if2.sum_out;
    assign co[2] = if2.cout; assign ov[2] = if2.ovf; assign zr[2] = if2.zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result packed as {ovf, zero, cout, sum}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] full;
        logic [15:0] r;
        logic        o;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   full = {1'b0, a} + {1'b0, b};
        r = full[15:0];
        if (s) o = (a[15] != b[15]) && (r[15] != a[15]);
        else   o = (a[15] == b[15]) && (r[15] != a[15]);
        return {o, (r == 16'd0), full[16], r};
    endfunction

    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input int lat, input string tag, output logic [18:0] got);
        logic [18:0] exp;
        int n;
        exp = model(a, b, s);
        @(negedge clk);
        ta = a; tbv = b; ts = s; sv[idx] = 1'b1;
        chk({tag, "_ready"}, 32'(sr[idx]), 32'd1);
        @(posedge clk); #1;
        sv[idx] = 1'b0;
        n = 0;
        while (!dv[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        got = {ov[idx], zr[idx], co[idx], so[idx]};
        chk({tag, "_result"}, 32'(got), 32'(exp));
        if (dr[idx]) begin
            @(posedge clk); #1;
            chk({tag, "_drop"}, {30'd0, dv[idx], sr[idx]}, 32'b01);
        end
    endtask

    initial begin
        logic [18:0] got;
        logic [18:0] held;
        int lats [3];
        lats[0] = 4; lats[1] = 16; lats[2] = 1;
        rst = 1'b1; ta = '0; tbv = '0; ts = 1'b0;
        for (int i = 0; i < 3; i++) begin sv[i] = 1'b0; dr[i] = 1'b1; end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {26'd0, sr[0], dv[0], co[0], ov[0], zr[0], (so[0] == 16'd0)}, 32'b100001);
        rst = 1'b0;

        run_op(0, 16'h1234, 16'h0FCC, 1'b0, 4, "add_basic", got);
        chk("add_basic_const", 32'(got), 32'({1'b0, 1'b0, 1'b0, 16'h2200}));
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 4, "add_wrap", got);
        chk("add_wrap_const", 32'(got), 32'({1'b0, 1'b1, 1'b1, 16'h0000}));
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 4, "add_ovf", got);
        chk("add_ovf_const", 32'(got), 32'({1'b1, 1'b0, 1'b0, 16'h8000}));
        run_op(0, 16'h0005, 16'h0007, 1'b1, 4, "sub_neg", got);
        chk("sub_neg_const", 32'(got), 32'({1'b0, 1'b0, 1'b0, 16'hFFFE}));
        run_op(0, 16'h8000, 16'h0001, 1'b1, 4, "sub_ovf", got);
        chk("sub_ovf_const", 32'(got), 32'({1'b1, 1'b0, 1'b1, 16'h7FFF}));
        run_op(0, 16'h1234, 16'h0000, 1'b1, 4, "sub_b0", got);
        chk("sub_b0_const", 32'(got), 32'({1'b0, 1'b0, 1'b1, 16'h1234}));

        // Back-pressure: results must hold while done_ready is low.
        dr[0] = 1'b0;
        run_op(0, 16'hABCD, 16'h1111, 1'b1, 4, "hold", held);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sv[0] = ~sv[0]; ta = 16'($urandom); ts = ~ts;
            @(posedge clk); #1;
            chk("hold_valid", 32'(dv[0]), 32'd1);
            chk("hold_outputs", 32'({ov[0], zr[0], co[0], so[0]}), 32'(model(16'hABCD, 16'h1111, 1'b1)));
        end
        @(negedge clk);
        sv[0] = 1'b0; dr[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", {30'd0, dv[0], sr[0]}, 32'b01);

        // Reset during the second RUN cycle aborts the op.
        @(negedge clk);
        ta = 16'h4444; tbv = 16'h2222; ts = 1'b0; sv[0] = 1'b1;
        @(posedge clk); #1;
        sv[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_reset", {26'd0, sr[0], dv[0], co[0], ov[0], zr[0], (so[0] == 16'd0)}, 32'b100001);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(dv[0]), 32'd0);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 4, "after_abort", got);
        chk("after_abort_sum", 32'(got[15:0]), 32'h0002);

        // Reset wins over a same-cycle request.
        @(negedge clk);
        rst = 1'b1; sv[0] = 1'b1; ta = 16'h0F0F;
        @(posedge clk); #1;
        chk("rst_priority", {30'd0, sr[0], dv[0]}, 32'b10);
        rst = 1'b0; sv[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_priority_idle", 32'(sr[0]), 32'd1);

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 3; j++) begin
                run_op(j, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), lats[j],
                       $sformatf("rand_u%0d", j), got);
            end
        end
        run_op(1, 16'h7FFF, 16'hFFFF, 1'b1, 16, "d1_sub_ovf", got);
        run_op(2, 16'h8000, 16'h8000, 1'b0, 1, "d16_add_ovf", got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
